// File: rtl/alu_pkg.sv
// Shared definitions for the add/subtract pipeline.
// Holds op encodings, the status-flag bundle and WIDTH-dependent limit constants.
// Limit helpers return MAX_W-bit values; callers truncate to their own WIDTH.
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest operand the limit helpers can describe.
  localparam int MAX_W = 64;

  typedef struct packed {
    logic ovf;
    logic carry;
    logic zero;
    logic neg;
  } flags_t;

  localparam int FLAGS_W = $bits(flags_t);

  // All-ones in the low w bits.
  function automatic logic [MAX_W-1:0] umax_of(input int w);
    return (w >= MAX_W) ? {MAX_W{1'b1}} : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] umin_of(input int w);
    return (w > 0) ? {MAX_W{1'b0}} : {MAX_W{1'b0}};
  endfunction

  // 0111..1 in the low w bits.
  function automatic logic [MAX_W-1:0] smax_of(input int w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // 1000..0 in the low w bits.
  function automatic logic [MAX_W-1:0] smin_of(input int w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/pipe_stage.sv
// Elastic register stage: one W-bit payload slot with valid/ready.
// Ports: clk/rst, upstream in_valid/in_ready/in_data, downstream out_valid/out_ready/out_data.
// in_ready is combinational (empty, or the held beat leaves this cycle).
// Payload only loads on an accepted beat, so outputs hold still while stalled.
module pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         valid;
  logic [W-1:0] data;

  assign in_ready  = !valid || out_ready;
  assign out_valid = valid;
  assign out_data  = data;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (in_ready) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/addsub_pipe.sv
// Add/subtract unit with optional saturation, status flags and a valid/ready pipeline.
// Ports: clk/rst, input beat (in_valid/in_ready, in_a, in_b, in_op, in_signed, in_sat),
//        output beat (out_valid/out_ready, out_result, out_ovf, out_carry, out_zero, out_neg).
// Arithmetic is combinational ahead of the first register; the remaining LATENCY-1
// stages only carry {result, flags}. WIDTH must lie in 4..alu_pkg::MAX_W.
module addsub_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_op,
  input  logic             in_signed,
  input  logic             in_sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg
);

  localparam int PW = WIDTH + FLAGS_W;

  localparam logic [WIDTH-1:0] UMAX = WIDTH'(umax_of(WIDTH));
  localparam logic [WIDTH-1:0] UMIN = WIDTH'(umin_of(WIDTH));
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax_of(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin_of(WIDTH));

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             carry;
  logic             ovf_signed;
  logic [WIDTH-1:0] result;
  flags_t           flags;
  logic [PW-1:0]    payload;

  // Subtraction is A + ~B + 1; the extra sum bit is carry-out, inverted to become borrow.
  always_comb begin
    b_eff      = (in_op == OP_SUB) ? ~in_b : in_b;
    sum        = {1'b0, in_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, in_op};
    carry      = (in_op == OP_SUB) ? ~sum[WIDTH] : sum[WIDTH];
    // Like-signed addends producing a result of the other sign.
    ovf_signed = (in_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != in_a[WIDTH-1]);

    flags.ovf   = in_signed ? ovf_signed : carry;
    flags.carry = carry;

    result = sum[WIDTH-1:0];
    if (in_sat && flags.ovf) begin
      if (in_signed) begin
        // A signed overflow always goes in A's direction.
        result = in_a[WIDTH-1] ? SMIN : SMAX;
      end else begin
        result = (in_op == OP_SUB) ? UMIN : UMAX;
      end
    end

    flags.zero = (result == '0);
    flags.neg  = in_signed & result[WIDTH-1];
  end

  assign payload = {result, flags};

  // Stage k takes its input from stage k-1 (or the arithmetic) and its ready
  // from stage k+1 (or out_ready).
  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    logic          prev_valid;
    logic [PW-1:0] prev_data;
    logic          up_ready;
    logic          valid;
    logic [PW-1:0] data;
    logic          next_ready;

    if (k == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_data  = payload;
    end else begin : g_link
      assign prev_valid = g_stage[k-1].valid;
      assign prev_data  = g_stage[k-1].data;
    end

    if (k == LATENCY - 1) begin : g_tail
      assign next_ready = out_ready;
    end else begin : g_chain
      assign next_ready = g_stage[k+1].up_ready;
    end

    pipe_stage #(.W(PW)) u_stage (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (prev_valid),
      .in_ready  (up_ready),
      .in_data   (prev_data),
      .out_valid (valid),
      .out_ready (next_ready),
      .out_data  (data)
    );
  end

  flags_t out_flags;

  assign in_ready   = g_stage[0].up_ready;
  assign out_valid  = g_stage[LATENCY-1].valid;
  assign out_result = g_stage[LATENCY-1].data[PW-1:FLAGS_W];
  assign out_flags  = flags_t'(g_stage[LATENCY-1].data[FLAGS_W-1:0]);
  assign out_ovf    = out_flags.ovf;
  assign out_carry  = out_flags.carry;
  assign out_zero   = out_flags.zero;
  assign out_neg    = out_flags.neg;

endmodule

// File: tb/tb_addsub_pipe.sv
// Directed bench for addsub_pipe at WIDTH=32, LATENCY=2.
// Covers reset state, arithmetic/saturation/flag vectors, backpressure, full-rate streaming
// and reset with beats in flight. Inputs change on the falling edge, outputs are read there too.
module tb_addsub_pipe;

  localparam int W   = 32;
  localparam int LAT = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_op;
  logic         in_signed;
  logic         in_sat;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_ovf;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  addsub_pipe #(.WIDTH(W), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_op      (in_op),
    .in_signed  (in_signed),
    .in_sat     (in_sat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf),
    .out_carry  (out_carry),
    .out_zero   (out_zero),
    .out_neg    (out_neg)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         op;
    logic         sgn;
    logic         sat;
    logic [W-1:0] res;
    logic [3:0]   fl;   // {ovf, carry, zero, neg}
  } vec_t;

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_op = 1'b0; in_signed = 1'b0; in_sat = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_result !== '0) begin
      errors++; $display("FAIL reset_out_result: got %h expected 0", out_result);
    end
    checks++;
    if ({out_ovf, out_carry, out_zero, out_neg} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b expected 0000", {out_ovf, out_carry, out_zero, out_neg});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready);
    end
  endtask

  task automatic test_arith();
    vec_t v [12];
    v[0]  = '{32'h0000_0008, 32'h0000_0014, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFF4, 4'b0101};
    v[1]  = '{32'hF000_0005, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 32'h7000_0006, 4'b1000};
    v[2]  = '{32'hF000_0005, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b1, 32'h8000_0000, 4'b1001};
    v[3]  = '{32'h7FFF_FFFF, 32'hF000_0004, 1'b1, 1'b1, 1'b0, 32'h8FFF_FFFB, 4'b1101};
    v[4]  = '{32'h7FFF_FFFF, 32'hF000_0004, 1'b1, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1100};
    v[5]  = '{32'h0000_0008, 32'h0000_0014, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFF4, 4'b1100};
    v[6]  = '{32'h0000_0008, 32'h0000_0014, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 4'b1110};
    v[7]  = '{32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 1'b0, 32'h0000_0010, 4'b1100};
    v[8]  = '{32'hFFFF_FFF0, 32'h0000_0020, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 4'b1100};
    v[9]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF, 4'b1000};
    v[10] = '{32'h0000_0005, 32'hFFFF_FFFB, 1'b0, 1'b1, 1'b0, 32'h0000_0000, 4'b0110};
    v[11] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 4'b1101};
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_a = v[i].a; in_b = v[i].b;
      in_op = v[i].op; in_signed = v[i].sgn; in_sat = v[i].sat;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++; $display("FAIL arith_in_ready[%0d]: got %b expected 1", i, in_ready);
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, out_result, out_ovf, out_carry, out_zero, out_neg} !== {1'b1, v[i].res, v[i].fl}) begin
        errors++;
        $display("FAIL arith[%0d]: got valid=%b res=%h ovf/carry/zero/neg=%b expected valid=1 res=%h flags=%b",
                 i, out_valid, out_result, {out_ovf, out_carry, out_zero, out_neg}, v[i].res, v[i].fl);
      end
    end
    @(negedge clk);
  endtask

  // Streams n unsigned adds (k + base) with out_ready low in cycles stall_lo..stall_hi.
  task automatic run_stream(input int n, input int stall_lo, input int stall_hi,
                            input logic [W-1:0] base, output int last_rx);
    int           sent = 0;
    int           rcv  = 0;
    int           cyc  = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res   = '0;
    logic         exp_rdy;
    last_rx = -1;
    in_op = 1'b0; in_signed = 1'b0; in_sat = 1'b0; in_b = base;
    while (rcv < n && cyc < 60) begin
      @(negedge clk);
      out_ready = !(cyc >= stall_lo && cyc <= stall_hi);
      in_valid  = (sent < n);
      in_a      = W'(sent);
      #1;
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_result !== prev_res) begin
          errors++; $display("FAIL stall_hold cyc %0d: got valid=%b res=%h expected valid=1 res=%h",
                             cyc, out_valid, out_result, prev_res);
        end
      end
      exp_rdy = !((sent - rcv) == LAT && !out_ready);
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++; $display("FAIL stream_in_ready cyc %0d: got %b expected %b", cyc, in_ready, exp_rdy);
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = out_result;
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (out_result !== base + W'(rcv)) begin
          errors++; $display("FAIL stream_order beat %0d: got %h expected %h", rcv, out_result, base + W'(rcv));
        end
        rcv++;
        last_rx = cyc;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      cyc++;
    end
    checks++;
    if (rcv != n) begin
      errors++; $display("FAIL stream_count: got %0d beats expected %0d (cycle budget)", rcv, n);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL stream_no_extra: got out_valid=%b expected 0", out_valid);
      end
    end
  endtask

  task automatic test_backpressure();
    int last;
    run_stream(6, 2, 5, 32'h0000_0100, last);
  endtask

  task automatic test_back_to_back();
    int last;
    run_stream(8, -1, -1, 32'h0001_0000, last);
    checks++;
    if (last != 8 + LAT - 1) begin
      errors++; $display("FAIL back_to_back_last_cycle: got %0d expected %0d", last, 8 + LAT - 1);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_op = 1'b0; in_signed = 1'b0; in_sat = 1'b0; in_b = 32'h0000_0011;
    @(negedge clk);
    in_valid = 1'b1; in_a = 32'h0000_0055;
    @(negedge clk);
    in_a = 32'h0000_0066;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h0000_0066) begin
      errors++; $display("FAIL mid_inflight: got valid=%b res=%h expected valid=1 res=00000066", out_valid, out_result);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_result !== '0 || {out_ovf, out_carry, out_zero, out_neg} !== 4'b0000) begin
      errors++; $display("FAIL mid_out_data: got res=%h flags=%b expected 0", out_result, {out_ovf, out_carry, out_zero, out_neg});
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL mid_stale_beat cyc %0d: got out_valid=%b expected 0", j, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
